trap_ctrl: RTL and testbench

- Machine-mode trap/return sequencer sitting directly downstream of the privileged/CSR block in the M stage.
- Consumes the pending-interrupt vector, mstatus.MIE, the privilege level, mtvec and mepc, together with M-stage exception and mret indications.
- Selects at most one event per accepted M-stage slot and produces the one-cycle trap/mret strobes (is_trap, mcause, exc_pc, mret) that the CSR file latches.
- Drives the pipeline flush and the fetch PC redirect, then holds the pipeline flushed for a fixed number of cycles before accepting the next event.

---
 rtl/trap_ctrl.sv | 128 ++++++++++++
 tb/tb_trap_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl.sv
// rtl/trap_ctrl.sv - machine-mode trap/mret sequencer with redirect and flush window
module trap_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        stallM_i,
    input  logic        instr_validM_i,
    input  logic [31:0] pcM_i,
    input  logic        exc_validM_i,
    input  logic [4:0]  exc_causeM_i,
    input  logic        mretM_i,
    input  logic [2:0]  irq_pending_i,
    input  logic        mstatus_mie_i,
    input  logic [1:0]  priv_lvl_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    output logic        is_trap_o,
    output logic [31:0] mcause_o,
    output logic [31:0] exc_pc_o,
    output logic        csr_mret_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o,
    output logic        flush_o,
    output logic        busy_o
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        IDLE,
        FLUSH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;

    logic        irq_en;
    logic        irq_take;
    logic        accept;
    logic [4:0]  irq_code;
    logic [31:0] base;
    logic [31:0] irq_target;

    assign irq_en   = (priv_lvl_i != 2'b11) | mstatus_mie_i;
    assign irq_take = irq_en & (|irq_pending_i) & instr_validM_i;
    assign accept   = (state == IDLE) & ~stallM_i & instr_validM_i;
    assign base     = {mtvec_i[31:2], 2'b00};

    // Pick the highest-priority pending interrupt code and its handler address
    always_comb begin
        irq_code = 5'd0;
        if (irq_pending_i[2]) begin
            irq_code = 5'd11;
        end else if (irq_pending_i[0]) begin
            irq_code = 5'd3;
        end else if (irq_pending_i[1]) begin
            irq_code = 5'd7;
        end
        irq_target = base;
        if (mtvec_i[1:0] == 2'b01) begin
            irq_target = base + {25'd0, irq_code, 2'b00};
        end
    end

    // Event acceptance, strobe generation and the post-redirect flush countdown
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state            <= IDLE;
            cnt              <= '0;
            is_trap_o        <= 1'b0;
            mcause_o         <= 32'd0;
            exc_pc_o         <= 32'd0;
            csr_mret_o       <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= 32'd0;
            flush_o          <= 1'b0;
            busy_o           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (irq_take || exc_validM_i || mretM_i)) begin
                        state            <= FLUSH;
                        cnt              <= CW'(FLUSH_CYCLES);
                        redirect_valid_o <= 1'b1;
                        flush_o          <= 1'b1;
                        busy_o           <= 1'b1;
                        if (irq_take) begin
                            is_trap_o     <= 1'b1;
                            mcause_o      <= {1'b1, 26'd0, irq_code};
                            exc_pc_o      <= pcM_i;
                            redirect_pc_o <= irq_target;
                        end else if (exc_validM_i) begin
                            is_trap_o     <= 1'b1;
                            mcause_o      <= {1'b0, 26'd0, exc_causeM_i};
                            exc_pc_o      <= pcM_i;
                            redirect_pc_o <= base;
                        end else begin
                            csr_mret_o    <= 1'b1;
                            redirect_pc_o <= mepc_i;
                        end
                    end
                end
                FLUSH: begin
                    // The strobe cycle does not consume the countdown, so flush
                    // stays high for the strobe cycle plus FLUSH_CYCLES more.
                    is_trap_o        <= 1'b0;
                    csr_mret_o       <= 1'b0;
                    redirect_valid_o <= 1'b0;
                    if (!redirect_valid_o) begin
                        if (cnt == CW'(1)) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            flush_o <= 1'b0;
                            busy_o  <= 1'b0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// tb/tb_trap_ctrl.sv - directed self-checking bench for trap_ctrl
module tb_trap_ctrl;

    logic        clk_i;
    logic        rstn_i;
    logic        stallM_i;
    logic        instr_validM_i;
    logic [31:0] pcM_i;
    logic        exc_validM_i;
    logic [4:0]  exc_causeM_i;
    logic        mretM_i;
    logic [2:0]  irq_pending_i;
    logic        mstatus_mie_i;
    logic [1:0]  priv_lvl_i;
    logic [31:0] mtvec_i;
    logic [31:0] mepc_i;
    logic        is_trap_o;
    logic [31:0] mcause_o;
    logic [31:0] exc_pc_o;
    logic        csr_mret_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    trap_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk_i            (clk_i),
        .rstn_i           (rstn_i),
        .stallM_i         (stallM_i),
        .instr_validM_i   (instr_validM_i),
        .pcM_i            (pcM_i),
        .exc_validM_i     (exc_validM_i),
        .exc_causeM_i     (exc_causeM_i),
        .mretM_i          (mretM_i),
        .irq_pending_i    (irq_pending_i),
        .mstatus_mie_i    (mstatus_mie_i),
        .priv_lvl_i       (priv_lvl_i),
        .mtvec_i          (mtvec_i),
        .mepc_i           (mepc_i),
        .is_trap_o        (is_trap_o),
        .mcause_o         (mcause_o),
        .exc_pc_o         (exc_pc_o),
        .csr_mret_o       (csr_mret_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .busy_o           (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic quiet_inputs();
        stallM_i       = 1'b0;
        instr_validM_i = 1'b0;
        exc_validM_i   = 1'b0;
        exc_causeM_i   = 5'd0;
        mretM_i        = 1'b0;
        irq_pending_i  = 3'b000;
    endtask

    initial begin
        quiet_inputs();
        pcM_i         = 32'd0;
        mstatus_mie_i = 1'b0;
        priv_lvl_i    = 2'b11;
        mtvec_i       = 32'd0;
        mepc_i        = 32'd0;
        rstn_i        = 1'b0;
        repeat (2) @(negedge clk_i);

        // reset state
        check("rst_is_trap", {31'd0, is_trap_o}, 32'd0);
        check("rst_flush",   {31'd0, flush_o},   32'd0);
        check("rst_busy",    {31'd0, busy_o},    32'd0);
        check("rst_mcause",  mcause_o,           32'd0);
        check("rst_redir",   redirect_pc_o,      32'd0);
        rstn_i = 1'b1;

        // synchronous exception, non-vectored even with mode 1
        @(negedge clk_i);
        instr_validM_i = 1'b1; exc_validM_i = 1'b1; exc_causeM_i = 5'd2;
        pcM_i = 32'h100; mtvec_i = 32'h8000_0001;
        @(negedge clk_i);
        quiet_inputs();
        check("exc_is_trap",  {31'd0, is_trap_o},        32'd1);
        check("exc_rv",       {31'd0, redirect_valid_o}, 32'd1);
        check("exc_mcause",   mcause_o,                  32'h2);
        check("exc_pc",       exc_pc_o,                  32'h100);
        check("exc_redir",    redirect_pc_o,             32'h8000_0000);
        check("exc_flush1",   {31'd0, flush_o},          32'd1);
        check("exc_busy1",    {31'd0, busy_o},           32'd1);
        @(negedge clk_i);
        check("exc_strobe_off", {31'd0, is_trap_o},        32'd0);
        check("exc_rv_off",     {31'd0, redirect_valid_o}, 32'd0);
        check("exc_flush2",     {31'd0, flush_o},          32'd1);
        check("exc_mcause_hold", mcause_o,                 32'h2);
        @(negedge clk_i);
        check("exc_flush3",   {31'd0, flush_o}, 32'd1);
        @(negedge clk_i);
        check("exc_flush_end", {31'd0, flush_o}, 32'd0);
        check("exc_busy_end",  {31'd0, busy_o},  32'd0);

        // vectored timer interrupt
        instr_validM_i = 1'b1; irq_pending_i = 3'b010; mstatus_mie_i = 1'b1;
        priv_lvl_i = 2'b11; pcM_i = 32'h200; mtvec_i = 32'h1001;
        @(negedge clk_i);
        quiet_inputs();
        check("tmr_is_trap", {31'd0, is_trap_o}, 32'd1);
        check("tmr_mcause",  mcause_o,           32'h8000_0007);
        check("tmr_redir",   redirect_pc_o,      32'h101C);
        check("tmr_pc",      exc_pc_o,           32'h200);
        repeat (3) @(negedge clk_i);
        check("tmr_busy_end", {31'd0, busy_o}, 32'd0);

        // masked in M mode with MIE=0
        instr_validM_i = 1'b1; irq_pending_i = 3'b100; mstatus_mie_i = 1'b0;
        priv_lvl_i = 2'b11; pcM_i = 32'h280;
        @(negedge clk_i);
        check("mask_is_trap", {31'd0, is_trap_o}, 32'd0);
        check("mask_busy",    {31'd0, busy_o},    32'd0);
        // same interrupt from U mode is taken
        priv_lvl_i = 2'b00;
        @(negedge clk_i);
        quiet_inputs();
        check("umode_is_trap", {31'd0, is_trap_o}, 32'd1);
        check("umode_mcause",  mcause_o,           32'h8000_000B);
        check("umode_redir",   redirect_pc_o,      32'h102C);
        repeat (3) @(negedge clk_i);

        // simultaneous irq + exception + mret: software irq wins
        instr_validM_i = 1'b1; irq_pending_i = 3'b001; mstatus_mie_i = 1'b1;
        priv_lvl_i = 2'b11; exc_validM_i = 1'b1; exc_causeM_i = 5'd5; mretM_i = 1'b1;
        mtvec_i = 32'h2000; mepc_i = 32'h440; pcM_i = 32'h300;
        @(negedge clk_i);
        quiet_inputs();
        check("sim_is_trap", {31'd0, is_trap_o},  32'd1);
        check("sim_mret",    {31'd0, csr_mret_o}, 32'd0);
        check("sim_mcause",  mcause_o,            32'h8000_0003);
        check("sim_redir",   redirect_pc_o,       32'h2000);
        check("sim_pc",      exc_pc_o,            32'h300);
        repeat (3) @(negedge clk_i);

        // mret alone
        instr_validM_i = 1'b1; mretM_i = 1'b1;
        @(negedge clk_i);
        quiet_inputs();
        check("mret_strobe",  {31'd0, csr_mret_o},       32'd1);
        check("mret_is_trap", {31'd0, is_trap_o},        32'd0);
        check("mret_rv",      {31'd0, redirect_valid_o}, 32'd1);
        check("mret_redir",   redirect_pc_o,             32'h440);
        check("mret_mcause_hold", mcause_o,              32'h8000_0003);
        check("mret_flush",   {31'd0, flush_o},          32'd1);
        @(negedge clk_i);
        check("mret_strobe_off", {31'd0, csr_mret_o}, 32'd0);
        repeat (2) @(negedge clk_i);

        // stalled exception waits for the stall to drop
        instr_validM_i = 1'b1; exc_validM_i = 1'b1; exc_causeM_i = 5'd7;
        pcM_i = 32'h500; stallM_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("stall_no_trap", {31'd0, is_trap_o}, 32'd0);
            check("stall_no_busy", {31'd0, busy_o},    32'd0);
            check("stall_redir_hold", redirect_pc_o,   32'h440);
        end
        stallM_i = 1'b0;
        @(negedge clk_i);
        quiet_inputs();
        check("unstall_is_trap", {31'd0, is_trap_o}, 32'd1);
        check("unstall_mcause",  mcause_o,           32'h7);
        check("unstall_redir",   redirect_pc_o,      32'h2000);
        // new exception during FLUSH is ignored
        instr_validM_i = 1'b1; exc_validM_i = 1'b1; exc_causeM_i = 5'd4; pcM_i = 32'h600;
        @(negedge clk_i);
        quiet_inputs();
        check("flushwin_no_trap", {31'd0, is_trap_o}, 32'd0);
        check("flushwin_mcause",  mcause_o,           32'h7);
        check("flushwin_pc",      exc_pc_o,           32'h500);
        check("flushwin_flush",   {31'd0, flush_o},   32'd1);
        @(negedge clk_i);
        check("flushwin_flush3",  {31'd0, flush_o},   32'd1);
        @(negedge clk_i);
        check("flushwin_end_flush", {31'd0, flush_o},   32'd0);
        check("flushwin_end_trap",  {31'd0, is_trap_o}, 32'd0);

        // async reset in the middle of FLUSH
        instr_validM_i = 1'b1; exc_validM_i = 1'b1; exc_causeM_i = 5'd1; pcM_i = 32'h700;
        @(negedge clk_i);
        quiet_inputs();
        check("ar_flush_pre", {31'd0, flush_o}, 32'd1);
        @(negedge clk_i);
        #2 rstn_i = 1'b0;
        #1;
        check("ar_flush", {31'd0, flush_o},   32'd0);
        check("ar_busy",  {31'd0, busy_o},    32'd0);
        check("ar_mcause", mcause_o,          32'd0);
        check("ar_redir",  redirect_pc_o,     32'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(negedge clk_i);
        check("ar_idle_busy", {31'd0, busy_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
